multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Control sequencer for the multicycle RISC datapath. Walks each instruction through
//  FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives every datapath strobe and mux select,
//  handshakes with memory via mem_ready, and exports its state code (State) for the bench.
//  Traps illegal opcodes and memory timeouts; counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles per memory access; 0 = timeout disabled
//  CNT_W        16  width of instr_count
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  op_code      in   6      opcode field from IR; valid from DECODE until next FETCH completes
//  zero         in   1      ALU zero flag (combinational, current cycle)
//  mem_ready    in   1      memory done; completes the pending access in the same cycle
//  State        out  5      current state code
//  pc_we        out  1      PC write enable
//  pc_src       out  2      00 PC+1, 01 branch target, 10 jump target
//  ir_we        out  1      IR write enable
//  mem_rd       out  1      memory read request
//  mem_wr       out  1      memory write request
//  alu_src_b    out  1      0 register, 1 immediate
//  alu_op       out  2      00 ADD, 01 SUB, 10 AND
//  reg_we       out  1      register file write enable
//  reg_dst      out  1      1 rd (R-type), 0 rt (I-type)
//  wb_sel       out  1      0 ALUOut, 1 memory data
//  halted       out  1      high in HALT
//  illegal      out  1      high in ERROR entered on bad opcode or bad state code
//  timeout      out  1      high in ERROR entered on memory timeout
//  instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Encoding: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC_R, 4 EXEC_I, 5 ALU_WB, 6 ADDR, 7 MEM_RD,
//   8 LOAD_WB, 9 MEM_WR, 10 BRANCH, 11 JUMP, 12 HALT, 13 ERROR.
//  Opcodes: 00 AND, 01 ADD, 02 SUB (R); 03 ANDI, 04 ADDI (I); 05 LW, 06 SW;
//   07 BEQ, 08 BNE; 09 JMP; 0A HALT. Any other opcode is illegal.
//  Strobe outputs are decoded from the state register, op_q, zero and mem_ready. Strobes
//   not listed for a state are 0; unlisted selects are 0.
//  rst low: State=0, op_q=0, instr_count=0, wait counter=0, all strobes and flags 0.
//   This takes effect immediately (async), including mid-access; no memory strobe may
//   stay asserted.
//  IDLE: no strobes. Goes to FETCH on the next cycle.
//  FETCH: mem_rd=1. On mem_ready: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
//  DECODE: latch op_code into op_q. Next state by opcode: R->EXEC_R, I->EXEC_I,
//   LW/SW->ADDR, BEQ/BNE->BRANCH, JMP->JUMP, HALT->HALT, illegal->ERROR.
//  EXEC_R: alu_op from op_q (AND=10, ADD=00, SUB=01). Next: ALU_WB.
//  EXEC_I: alu_src_b=1, alu_op from op_q. Next: ALU_WB.
//  ALU_WB: reg_we=1, wb_sel=0, reg_dst=1 if op_q is R-type. Next: FETCH.
//  ADDR: alu_src_b=1, alu_op=00. Next: MEM_RD for LW, MEM_WR for SW.
//  MEM_RD: mem_rd=1. Wait for mem_ready, then go to LOAD_WB.
//  LOAD_WB: reg_we=1, wb_sel=1. Next: FETCH.
//  MEM_WR: mem_wr=1. Wait for mem_ready, then go to FETCH.
//  BRANCH: alu_op=01, pc_src=01. pc_we=(BEQ & zero)|(BNE & ~zero). Next: FETCH.
//  JUMP: pc_we=1, pc_src=10. Next: FETCH.
//  HALT: halted=1. Terminal until reset.
//  ERROR: illegal or timeout held high (sticky). Terminal until reset.
//  State codes 14-31: next state is ERROR with illegal=1.
//  Wait counter (FETCH/MEM_RD/MEM_WR):
//   - cleared on entry to a wait state;
//   - +1 each cycle mem_ready=0;
//   - if mem_ready=0 and count==MEM_TIMEOUT-1: go to ERROR with timeout=1;
//   - mem_ready=1 on that cycle wins, so the access completes normally.
//  Latency with mem_ready tied high: R/I-type 4 cycles, LW 5, SW 4, BRANCH/JMP 3.
//  Retire: instr_count +1 on the clock edge that leaves ALU_WB, LOAD_WB, BRANCH or JUMP,
//   or leaves MEM_WR when mem_ready=1. Wraps modulo 2^CNT_W. HALT does not count.
// TESTING
//  1 ADD, mem_ready=1: State 0,1,2,3,5,1; reg_we=1 only in 5 with reg_dst=1;
//    instr_count 0->1.
//  2 LW, mem_ready low 2 cycles in MEM_RD: State 1,2,6,7,7,7,8,1; mem_rd high all 3
//    cycles of 7; wb_sel=1 in 8.
//  3 BEQ zero=1 -> pc_we=1, pc_src=01 in state 10. BEQ zero=0 -> pc_we=0.
//    BNE zero=0 -> pc_we=1.
//  4 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> 4 cycles in state 1, then State=13,
//    timeout=1, mem_rd=0. Repeat with mem_ready=1 on 4th cycle -> DECODE.
//  5 op_code=6'h3F -> State 13, illegal=1. op_code=6'h0A -> State 12, halted=1,
//    count unchanged.
//  6 rst low mid-MEM_WR -> mem_wr=0 and State=0 immediately; rst high -> one cycle
//    IDLE, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Control sequencer for the multicycle RISC datapath. Steps each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives the datapath strobes
// and mux selects, handshakes with memory through mem_ready, traps illegal
// opcodes, bad state codes and memory timeouts, and counts retired instructions.
//
// Parameters
//   MEM_TIMEOUT  max consecutive wait cycles per memory access (0 disables)
//   CNT_W        width of instr_count
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   op_code      opcode field from IR (valid from DECODE until next FETCH completes)
//   zero         ALU zero flag, current cycle
//   mem_ready    memory done; completes the pending access this cycle
//   State        current state code
//   pc_we/pc_src PC write enable / PC source (00 PC+1, 01 branch, 10 jump)
//   ir_we        IR write enable
//   mem_rd/mem_wr memory read / write request
//   alu_src_b    ALU B operand (0 register, 1 immediate)
//   alu_op       00 ADD, 01 SUB, 10 AND
//   reg_we       register file write enable
//   reg_dst      1 rd (R-type), 0 rt (I-type)
//   wb_sel       0 ALUOut, 1 memory data
//   halted       high in HALT
//   illegal      high in ERROR entered on bad opcode or bad state code
//   timeout      high in ERROR entered on memory timeout
//   instr_count  retired-instruction count
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [4:0]       State,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    FETCH   = 5'd1,
    DECODE  = 5'd2,
    EXEC_R  = 5'd3,
    EXEC_I  = 5'd4,
    ALU_WB  = 5'd5,
    ADDR    = 5'd6,
    MEM_RD  = 5'd7,
    LOAD_WB = 5'd8,
    MEM_WR  = 5'd9,
    BRANCH  = 5'd10,
    JUMP    = 5'd11,
    HALT    = 5'd12,
    ERROR   = 5'd13
  } state_t;

  localparam logic [5:0] OP_AND  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_ANDI = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h05;
  localparam logic [5:0] OP_SW   = 6'h06;
  localparam logic [5:0] OP_BEQ  = 6'h07;
  localparam logic [5:0] OP_BNE  = 6'h08;
  localparam logic [5:0] OP_JMP  = 6'h09;
  localparam logic [5:0] OP_HALT = 6'h0A;

  // Wide enough to hold MEM_TIMEOUT-1, the last wait cycle before the trap.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t            state;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q;
  logic              timeout_q;
  logic              in_wait;
  logic              wait_expired;

  assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  // A ready on the final permitted cycle still completes the access.
  assign wait_expired = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  function automatic logic [1:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_AND, OP_ANDI: return 2'b10;
      OP_SUB:          return 2'b01;
      default:         return 2'b00;
    endcase
  endfunction

  // Wait counter restarts on every wait-state entry: it is held at zero
  // outside the wait states and cleared whenever an access completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= '0;
      wait_cnt    <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      instr_count <= '0;
    end else begin
      if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;

      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (mem_ready) state <= DECODE;
          else if (wait_expired) begin
            state     <= ERROR;
            timeout_q <= 1'b1;
          end
        end
        DECODE: begin
          op_q <= op_code;
          case (op_code)
            OP_AND, OP_ADD, OP_SUB: state <= EXEC_R;
            OP_ANDI, OP_ADDI:       state <= EXEC_I;
            OP_LW, OP_SW:           state <= ADDR;
            OP_BEQ, OP_BNE:         state <= BRANCH;
            OP_JMP:                 state <= JUMP;
            OP_HALT:                state <= HALT;
            default: begin
              state     <= ERROR;
              illegal_q <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I: state <= ALU_WB;
        ADDR: state <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (mem_ready) state <= LOAD_WB;
          else if (wait_expired) begin
            state     <= ERROR;
            timeout_q <= 1'b1;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            state       <= FETCH;
            instr_count <= instr_count + 1'b1;
          end else if (wait_expired) begin
            state     <= ERROR;
            timeout_q <= 1'b1;
          end
        end
        ALU_WB, LOAD_WB, BRANCH, JUMP: begin
          state       <= FETCH;
          instr_count <= instr_count + 1'b1;
        end
        HALT:  state <= HALT;
        ERROR: state <= ERROR;
        // Codes 14-31 can only arise from a corrupted state register.
        default: begin
          state     <= ERROR;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so that mem_ready and
  // zero act in the same cycle; IDLE (the reset state) drives nothing.
  always_comb begin
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    ir_we     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    case (state)
      FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ready;
        pc_we  = mem_ready;
      end
      EXEC_R: alu_op = alu_op_for(op_q);
      EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = alu_op_for(op_q);
      end
      ALU_WB: begin
        reg_we  = 1'b1;
        reg_dst = (op_q == OP_AND) || (op_q == OP_ADD) || (op_q == OP_SUB);
      end
      ADDR:    alu_src_b = 1'b1;
      MEM_RD:  mem_rd = 1'b1;
      LOAD_WB: begin
        reg_we = 1'b1;
        wb_sel = 1'b1;
      end
      MEM_WR:  mem_wr = 1'b1;
      BRANCH: begin
        alu_op = 2'b01;
        pc_src = 2'b01;
        pc_we  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
      end
      JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign State   = state;
  assign halted  = (state == HALT);
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule
